// File: rtl/logic_capture_mem_level_fifo.sv
// Capture-record FIFO between the capture front end and the memory writer.
// Adds an optional output register, live level, almost flags, flush and sticky errors.
module logic_capture_mem_level_fifo #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int OUT_REG = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic [WIDTH-1:0]  data_in_i,
    input  logic              push_i,
    output logic              accept_o,
    input  logic              pop_i,
    output logic              valid_o,
    output logic [WIDTH-1:0]  data_out_o,
    output logic [ADDR_W:0]   level_o,
    input  logic [ADDR_W:0]   afull_thresh_i,
    input  logic [ADDR_W:0]   aempty_thresh_i,
    output logic              afull_o,
    output logic              aempty_o,
    input  logic              err_clr_i,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam logic [ADDR_W:0] CAP = (ADDR_W+1)'(DEPTH + OUT_REG);

    logic [WIDTH-1:0]  ram [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   ram_cnt;
    logic [ADDR_W:0]   ram_cnt_nxt;
    logic [ADDR_W:0]   level;
    logic [ADDR_W:0]   level_nxt;
    logic              head;
    logic              push_ok;
    logic              pop_ok;
    logic              ram_rd;
    logic              ovf_set;
    logic              unf_set;

    assign accept_o = ~flush_i & (level != CAP);
    assign valid_o  = ~flush_i & head;
    assign push_ok  = push_i & accept_o;
    assign pop_ok   = pop_i & valid_o;
    assign level_o  = level;
    assign afull_o  = level >= afull_thresh_i;
    assign aempty_o = level <= aempty_thresh_i;

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            ram[wr_ptr] <= data_in_i;
        end
    end

    always_comb begin
        level_nxt = level;
        unique case ({push_ok, pop_ok})
            2'b10:   level_nxt = level + (ADDR_W+1)'(1);
            2'b01:   level_nxt = level - (ADDR_W+1)'(1);
            default: level_nxt = level;
        endcase
    end

    always_comb begin
        ram_cnt_nxt = ram_cnt;
        unique case ({push_ok, ram_rd})
            2'b10:   ram_cnt_nxt = ram_cnt + (ADDR_W+1)'(1);
            2'b01:   ram_cnt_nxt = ram_cnt - (ADDR_W+1)'(1);
            default: ram_cnt_nxt = ram_cnt;
        endcase
    end

    // Pointers roll over naturally since DEPTH == 2**ADDR_W
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ram_cnt <= '0;
            level   <= '0;
        end else if (flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            ram_cnt <= '0;
            level   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (ram_rd) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            ram_cnt <= ram_cnt_nxt;
            level   <= level_nxt;
        end
    end

    generate
        if (OUT_REG == 0) begin : g_direct
            assign head       = ram_cnt != '0;
            assign ram_rd     = pop_ok;
            assign data_out_o = ram[rd_ptr];
        end else begin : g_oreg
            logic             occ;
            logic             load;
            logic [WIDTH-1:0] hold;

            // Refill whenever the register is free or being drained this edge
            assign load       = ~flush_i & (ram_cnt != '0) & (~occ | pop_ok);
            assign ram_rd     = load;
            assign head       = occ;
            assign data_out_o = hold;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    occ <= 1'b0;
                end else if (flush_i) begin
                    occ <= 1'b0;
                end else if (load) begin
                    occ <= 1'b1;
                end else if (pop_ok) begin
                    occ <= 1'b0;
                end
            end

            always_ff @(posedge clk_i) begin
                if (load) begin
                    hold <= ram[rd_ptr];
                end
            end
        end
    endgenerate

    assign ovf_set = push_i & ~accept_o & ~flush_i;
    assign unf_set = pop_i & ~valid_o & ~flush_i;

    // A new error in the clearing cycle must not be lost
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            if (ovf_set) begin
                overflow_o <= 1'b1;
            end else if (err_clr_i) begin
                overflow_o <= 1'b0;
            end
            if (unf_set) begin
                underflow_o <= 1'b1;
            end else if (err_clr_i) begin
                underflow_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_logic_capture_mem_level_fifo.sv
// Bench for logic_capture_mem_level_fifo: DEPTH=4 instances with and without the
// output register, checked every cycle against queue models plus literal checks.
module tb_logic_capture_mem_level_fifo;

    localparam int W = 8;
    localparam int D = 4;
    localparam int A = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         push = 1'b0;
    logic         pop = 1'b0;
    logic         clr = 1'b0;
    logic [W-1:0] din = '0;
    logic [A:0]   afth = 3'd3;
    logic [A:0]   aeth = 3'd1;

    logic         acc0, vld0, af0, ae0, ovf0, unf0;
    logic [W-1:0] dout0;
    logic [A:0]   lvl0;
    logic         acc1, vld1, af1, ae1, ovf1, unf1;
    logic [W-1:0] dout1;
    logic [A:0]   lvl1;

    int checks = 0;
    int failures = 0;

    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    bit           v1;
    bit           mo0, mu0, mo1, mu1;

    always #5 clk = ~clk;

    logic_capture_mem_level_fifo #(
        .WIDTH(W), .DEPTH(D), .ADDR_W(A), .OUT_REG(0)
    ) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .data_in_i(din), .push_i(push), .accept_o(acc0),
        .pop_i(pop), .valid_o(vld0), .data_out_o(dout0),
        .level_o(lvl0), .afull_thresh_i(afth), .aempty_thresh_i(aeth),
        .afull_o(af0), .aempty_o(ae0), .err_clr_i(clr),
        .overflow_o(ovf0), .underflow_o(unf0)
    );

    logic_capture_mem_level_fifo #(
        .WIDTH(W), .DEPTH(D), .ADDR_W(A), .OUT_REG(1)
    ) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .data_in_i(din), .push_i(push), .accept_o(acc1),
        .pop_i(pop), .valid_o(vld1), .data_out_o(dout1),
        .level_o(lvl1), .afull_thresh_i(afth), .aempty_thresh_i(aeth),
        .afull_o(af1), .aempty_o(ae1), .err_clr_i(clr),
        .overflow_o(ovf1), .underflow_o(unf1)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: a queue of held records. With the output register, the head
    // is visible only once some record has survived from before the last edge.
    always @(posedge clk or negedge rst_n) begin
        bit a, v, pu, po;
        int surv;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            v1 = 0;
            mo0 = 0; mu0 = 0; mo1 = 0; mu1 = 0;
        end else begin
            a  = !flush && q0.size() != D;
            v  = !flush && q0.size() != 0;
            pu = push && a;
            po = pop && v;
            if (push && !a && !flush) mo0 = 1; else if (clr) mo0 = 0;
            if (pop && !v && !flush) mu0 = 1; else if (clr) mu0 = 0;
            if (flush) q0.delete();
            else begin
                if (po) void'(q0.pop_front());
                if (pu) q0.push_back(din);
            end

            a  = !flush && q1.size() != D + 1;
            v  = !flush && v1;
            pu = push && a;
            po = pop && v;
            if (push && !a && !flush) mo1 = 1; else if (clr) mo1 = 0;
            if (pop && !v && !flush) mu1 = 1; else if (clr) mu1 = 0;
            if (flush) begin
                q1.delete();
                v1 = 0;
            end else begin
                if (po) void'(q1.pop_front());
                surv = q1.size();
                if (pu) q1.push_back(din);
                v1 = surv > 0;
            end
        end
    end

    always @(negedge clk) begin
        int l0, l1;
        l0 = q0.size();
        l1 = q1.size();
        chk("acc0", acc0, !flush && l0 != D);
        chk("vld0", vld0, !flush && l0 != 0);
        if (!flush && l0 != 0) chk("dout0", dout0, q0[0]);
        chk("lvl0", lvl0, l0);
        chk("af0", af0, l0 >= afth);
        chk("ae0", ae0, l0 <= aeth);
        chk("ovf0", ovf0, mo0);
        chk("unf0", unf0, mu0);
        chk("acc1", acc1, !flush && l1 != D + 1);
        chk("vld1", vld1, !flush && v1);
        if (!flush && v1) chk("dout1", dout1, q1[0]);
        chk("lvl1", lvl1, l1);
        chk("af1", af1, l1 >= afth);
        chk("ae1", ae1, l1 <= aeth);
        chk("ovf1", ovf1, mo1);
        chk("unf1", unf1, mu1);
    end

    task automatic cyc(input bit p, input logic [W-1:0] d, input bit po,
                       input bit f, input bit c);
        push = p; din = d; pop = po; flush = f; clr = c;
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] seq [5];
        int pb;
        seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

        repeat (2) @(negedge clk);
        #1;
        chk("rst_lvl0", lvl0, 0);
        chk("rst_vld0", vld0, 0);
        chk("rst_acc0", acc0, 1);
        chk("rst_ovf0", ovf0, 0);
        chk("rst_vld1", vld1, 0);
        chk("rst_acc1", acc1, 1);
        rst_n = 1'b1;

        cyc(1, 8'h11, 0, 0, 0);
        chk("p1_vld0", vld0, 1);
        chk("p1_dout0", dout0, 8'h11);
        chk("p1_vld1", vld1, 0);
        chk("p1_ae0", ae0, 1);
        cyc(1, 8'h22, 0, 0, 0);
        chk("p2_vld1", vld1, 1);
        chk("p2_dout1", dout1, 8'h11);
        chk("p2_ae0", ae0, 0);
        cyc(1, 8'h33, 0, 0, 0);
        chk("p3_lvl0", lvl0, 3);
        chk("p3_af0", af0, 1);
        cyc(1, 8'h44, 0, 0, 0);
        chk("p4_acc0", acc0, 0);
        chk("p4_lvl0", lvl0, 4);
        chk("p4_acc1", acc1, 1);
        cyc(1, 8'h55, 0, 0, 0);
        chk("p5_ovf0", ovf0, 1);
        chk("p5_lvl1", lvl1, 5);
        chk("p5_acc1", acc1, 0);
        chk("p5_ovf1", ovf1, 0);

        for (int i = 0; i < 5; i++) begin
            if (i < 4) chk("drain_dout0", dout0, seq[i]);
            chk("drain_dout1", dout1, seq[i]);
            cyc(0, 8'h00, 1, 0, 0);
        end
        chk("dr_vld0", vld0, 0);
        chk("dr_lvl0", lvl0, 0);
        chk("dr_unf0", unf0, 1);
        chk("dr_ovf0_sticky", ovf0, 1);
        chk("dr_vld1", vld1, 0);
        chk("dr_unf1", unf1, 0);

        cyc(0, 8'h00, 0, 0, 1);
        chk("clr_ovf0", ovf0, 0);
        chk("clr_unf0", unf0, 0);

        for (int i = 0; i < 4; i++) cyc(1, 8'($urandom), 0, 0, 0);
        cyc(1, 8'h77, 0, 0, 1);
        chk("clrset_ovf0", ovf0, 1);
        chk("clrset_lvl1", lvl1, 5);

        cyc(0, 8'h00, 0, 1, 1);
        chk("fl_lvl0", lvl0, 0);
        chk("fl_ovf0", ovf0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 8'($urandom), 0, 0, 0);
        chk("pre_fl_lvl1", lvl1, 3);
        cyc(1, 8'hEE, 1, 1, 0);
        cyc(0, 8'h00, 0, 0, 0);
        chk("fpp_lvl0", lvl0, 0);
        chk("fpp_vld0", vld0, 0);
        chk("fpp_acc0", acc0, 1);
        chk("fpp_lvl1", lvl1, 0);
        chk("fpp_vld1", vld1, 0);
        chk("fpp_ovf0", ovf0, 0);
        chk("fpp_unf1", unf1, 0);

        for (int i = 0; i < 3; i++) cyc(1, 8'($urandom), 0, 0, 0);
        push = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("ar_lvl0", lvl0, 0);
        chk("ar_vld0", vld0, 0);
        chk("ar_lvl1", lvl1, 0);
        chk("ar_vld1", vld1, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1, 8'h5A, 0, 0, 0);
        chk("ar_dout0", dout0, 8'h5A);
        cyc(0, 8'h00, 0, 0, 0);
        chk("ar_vld1", vld1, 1);
        chk("ar_dout1", dout1, 8'h5A);
        cyc(0, 8'h00, 1, 0, 0);

        cyc(1, 8'($urandom), 0, 0, 0);
        cyc(1, 8'($urandom), 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(1, 8'($urandom), 1, 0, 0);
            chk("wrap_lvl0", lvl0, 2);
            chk("wrap_lvl1", lvl1, 2);
        end
        cyc(0, 8'h00, 1, 0, 0);
        cyc(0, 8'h00, 1, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 0) begin
                afth = 3'($urandom_range(0, 6));
                aeth = 3'($urandom_range(0, 6));
            end
            pb = ((i / 100) % 2 == 1) ? 75 : 35;
            cyc($urandom_range(0, 99) < pb, 8'($urandom),
                $urandom_range(0, 99) < 55,
                $urandom_range(0, 99) < 2,
                $urandom_range(0, 99) < 3);
        end
        cyc(0, 8'h00, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/logic_capture_mem_level_fifo.md
# logic_capture_mem_level_fifo

Parametrised successor to the capture-memory tracking FIFO. It buffers WIDTH-bit capture records between the capture front end and the memory writer. Over the basic push/pop FIFO it adds:
- an optional registered output stage;
- a live occupancy level with programmable almost-full and almost-empty flags;
- a synchronous flush;
- sticky overflow and underflow error flags.

## Interface
- WIDTH, 8, record width in bits
- DEPTH, 16, RAM entries; must equal 2**ADDR_W, minimum 2
- ADDR_W, 4, RAM pointer width
- OUT_REG, 0, 0 = RAM read drives data_out_o; 1 = head held in an output register (adds one entry of capacity)

- clk_i  in  1  clock, all logic on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- flush_i  in  1  synchronous flush, discards all contents
- data_in_i  in  WIDTH  push data
- push_i  in  1  push request
- accept_o  out  1  space available; push takes effect when push_i & accept_o
- pop_i  in  1  pop request
- valid_o  out  1  head data valid; pop takes effect when pop_i & valid_o
- data_out_o  out  WIDTH  head data (show-ahead)
- level_o  out  ADDR_W+1  entries held, including the output register
- afull_thresh_i  in  ADDR_W+1  almost-full threshold, quasi-static
- aempty_thresh_i  in  ADDR_W+1  almost-empty threshold, quasi-static
- afull_o  out  1  level_o >= afull_thresh_i
- aempty_o  out  1  level_o <= aempty_thresh_i
- err_clr_i  in  1  clears overflow_o and underflow_o
- overflow_o  out  1  sticky: push attempted while accept_o low
- underflow_o  out  1  sticky: pop attempted while valid_o low

## Operation
**Capacity and level**
- CAP = DEPTH + OUT_REG.
- level_o = RAM count + output-register occupancy. It is a registered count; width ADDR_W+1 holds CAP without overflow.

**Handshake flags**
- accept_o = ~flush_i & (level_o != CAP).
- valid_o = ~flush_i & head present:
  - OUT_REG=0: head present when RAM count != 0.
  - OUT_REG=1: head present when the output register is occupied.

**Data path**
- Push writes ram[wr_ptr] and increments wr_ptr.
- Pointers wrap modulo DEPTH through natural ADDR_W-bit rollover.

**OUT_REG=0**
- data_out_o = ram[rd_ptr], read combinationally.
- A pop increments rd_ptr.

**OUT_REG=1**
- The output register loads ram[rd_ptr] and increments rd_ptr on an edge where RAM count != 0 and (register empty, or a pop is accepted).
- The register is cleared to unoccupied on an edge where a pop is accepted and RAM is empty.
- data_out_o holds its last value while unoccupied.

**Simultaneous events**
- Push and pop in the same cycle: level unchanged; both take effect.
- Full with pop_i high: accept_o is still 0. There is no same-cycle pass-through.
- Empty with push_i high: valid_o is still 0. There is no bypass.

**Flush**
- On an edge with flush_i=1: pointers, counts and output-register occupancy are cleared, and level becomes 0.
- push_i and pop_i are ignored that cycle.
- RAM contents and the error flags are untouched.

**Error flags**
- overflow_o sets on push_i & ~accept_o & ~flush_i.
- underflow_o sets on pop_i & ~valid_o & ~flush_i.
- err_clr_i clears both; a set in the same cycle wins over the clear.

**Almost flags**
- afull_o and aempty_o are combinational compares of the registered level against the threshold ports (unsigned).

## Timing
**Reset**
- rst_ni low forces immediately: level_o=0, valid_o=0, accept_o=1 (if flush_i=0), overflow_o=0, underflow_o=0, pointers 0.
- data_out_o is don't-care, and RAM is not reset.
- Reset asserted mid-operation discards all contents with no partial state retained.
- Deassertion is synchronised externally; the first active edge is the one after deassertion.

**Latency**
- Push to valid_o: OUT_REG=0 gives 1 edge; OUT_REG=1 gives 2 edges when empty.
- Pop to next head: OUT_REG=0 is visible after the same edge. OUT_REG=1 is visible after the same edge if RAM count != 0 at that edge.
- level_o, afull_o and aempty_o update one edge after the accepted push, pop or flush.
- Flag set: overflow_o and underflow_o assert after the offending edge.

**Throughput**
- One push and one pop per cycle sustained, in both modes.

## Test plan
- **Fill/drain, DEPTH=4, OUT_REG=0:** push 0x11,0x22,0x33,0x44 on consecutive cycles -> accept_o=0 after the 4th edge, level_o=4. Pop 4 -> data 0x11..0x44 in order, valid_o=0, level_o=0.
- **Wrap with concurrent push/pop, OUT_REG=1:**
  - Preload 2 entries, then push and pop every cycle for 20 cycles -> level_o stays constant and output order matches input order across pointer wrap.
  - Push into empty -> valid_o rises 2 edges later.
  - With DEPTH=4, 5 entries are accepted before accept_o=0.
- **Thresholds:** afull_thresh_i=3, aempty_thresh_i=1, DEPTH=4, OUT_REG=0. Push 3 -> afull_o=1 at level 3; aempty_o=1 at levels 0 and 1, 0 at level 2.
- **Flush with push_i=pop_i=1 at level 3** -> next cycle level_o=0, valid_o=0, accept_o=1; the pushed word is not stored; no error flags set.
- **Errors:**
  - Push while full -> overflow_o=1 and stays set.
  - Pop while empty -> underflow_o=1.
  - err_clr_i alone -> both clear next edge.
  - err_clr_i with a concurrent overflow push -> overflow_o remains 1.
- **Async reset mid-stream:** drop rst_ni between edges at level 3 -> level_o=0, valid_o=0 without waiting for a clock edge. After release, push 0x5A -> head is 0x5A.
